// File: rtl/barrel_shift_pkg.sv
// Shared constants, FSM encoding and a reference rotate-left for the
// barrel_shift_arbiter slice.
package barrel_shift_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Bit-scatter formulation, deliberately unlike the shifter's datapath.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0]  d,
                                             input logic [SHAMT_W-1:0] s);
    logic [DATA_W-1:0]  r;
    logic [SHAMT_W-1:0] j;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      j    = SHAMT_W'(i) + s;
      r[j] = d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit rotate-left: o_data = (i_data << s) | (i_data >> (8 - s)).
module barrel_shifter
  import barrel_shift_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shift_amount,
  output logic [DATA_W-1:0]  o_data
);

  logic [2*DATA_W-1:0] w_dbl;

  // Bits shifted out of the low copy land in the top half, forming the rotation.
  assign w_dbl  = {i_data, i_data} << i_shift_amount;
  assign o_data = w_dbl[2*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin sharing of one barrel_shifter among NUM_REQ requesters, with a
// single registered response stage (one-cycle latency, full throughput).
module barrel_shift_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] i_req_shamt,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic [ID_W-1:0]           o_rsp_id,
  input  logic                      i_rsp_ready,
  output logic                      o_busy
);

  // Handshake: a beat moves on a rising edge when valid and ready are both
  // high; a requester holds valid and its payload stable until accepted.

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_found;
  logic               w_can_accept;
  logic               w_xfer;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SHAMT_W-1:0] w_sel_shamt;
  logic [DATA_W-1:0]  w_rot;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int              off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return t[ID_W-1:0];
  endfunction

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[wrap_idx(r_rr_ptr, i)]) begin
        w_found     = 1'b1;
        w_grant_idx = wrap_idx(r_rr_ptr, i);
      end
    end
  end

  // The output slot frees up in the same cycle it drains, so accept then too.
  assign w_can_accept = (r_state == ST_EMPTY) | i_rsp_ready;
  assign w_xfer       = w_found & w_can_accept & ~i_rst;

  always_comb begin
    o_req_ready = '0;
    if (w_xfer) o_req_ready[w_grant_idx] = 1'b1;
  end

  assign w_sel_data  = i_req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
  assign w_sel_shamt = i_req_shamt[int'(w_grant_idx)*SHAMT_W +: SHAMT_W];

  barrel_shifter u_shifter (
    .i_data         (w_sel_data),
    .i_shift_amount (w_sel_shamt),
    .o_data         (w_rot)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)                                   w_state_nxt = ST_FULL;
    else if (r_state == ST_FULL && i_rsp_ready)   w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_rr_ptr   <= '0;
      o_rsp_data <= '0;
      o_rsp_id   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        o_rsp_data <= w_rot;
        o_rsp_id   <= w_grant_idx;
        r_rr_ptr   <= wrap_idx(w_grant_idx, 1);
      end
    end
  end

  assign o_rsp_valid = (r_state == ST_FULL);
  assign o_busy      = (r_state == ST_FULL);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Scoreboard bench for barrel_shift_arbiter: directed vectors with hand-computed
// results, then a random soak checked against a round-robin/rotl model.
module tb_barrel_shift_arbiter;
  import barrel_shift_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + DATA_W;

  logic                        clk = 1'b0;
  logic                        i_rst;
  logic [NUM_REQ-1:0]          i_req_valid;
  logic [NUM_REQ*DATA_W-1:0]   i_req_data;
  logic [NUM_REQ*SHAMT_W-1:0]  i_req_shamt;
  logic [NUM_REQ-1:0]          o_req_ready;
  logic                        o_rsp_valid;
  logic [DATA_W-1:0]           o_rsp_data;
  logic [ID_W-1:0]             o_rsp_id;
  logic                        i_rsp_ready;
  logic                        o_busy;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  int           m_ptr  = 0;
  bit           m_full = 0;
  logic [3:0]   last_grant;

  barrel_shift_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_shamt (i_req_shamt),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_id    (o_rsp_id),
    .i_rsp_ready (i_rsp_ready),
    .o_busy      (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_d(input logic [7:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [11:0] pack_s(input logic [2:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, checks grant and busy against either the hand vector or
  // the model, and pushes the expected response for any transfer.
  task automatic step(input logic [3:0] vld, input logic [31:0] dat, input logic [11:0] sh,
                      input logic rdy, input bit hand, input logic [3:0] h_rdy,
                      input logic [W-1:0] h_rsp);
    logic [3:0] m_rdy;
    int         k;
    bit         found;
    @(negedge clk);
    i_req_valid = vld;
    i_req_data  = dat;
    i_req_shamt = sh;
    i_rsp_ready = rdy;
    #3;
    found = 0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (m_ptr + i) % NUM_REQ;
      if (!found && vld[j]) begin
        found = 1;
        k     = j;
      end
    end
    m_rdy = '0;
    if (found && (!m_full || rdy)) m_rdy[k] = 1'b1;
    check("busy", o_busy, m_full);
    if (hand) check("req_ready", o_req_ready, h_rdy);
    else      check("req_ready", o_req_ready, m_rdy);
    if (m_rdy != 0) begin
      if (hand) exp_q.push_back(h_rsp);
      else      exp_q.push_back({k[ID_W-1:0], rotl(dat[k*8 +: 8], sh[k*3 +: 3])});
      m_ptr  = (k + 1) % NUM_REQ;
      m_full = 1;
    end else if (rdy) begin
      m_full = 0;
    end
    last_grant = m_rdy;
  endtask

  task automatic idle(input logic rdy);
    step(4'b0000, 32'h0, 12'h0, rdy, 1, 4'b0000, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit           prev_stall = 0;
  logic [7:0]   prev_data;
  logic [1:0]   prev_id;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (i_rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_data", o_rsp_data, prev_data);
          check("hold_id", o_rsp_id, prev_id);
        end
        if (o_rsp_valid && i_rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got id %0d data %0h, expected none", o_rsp_id, o_rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp", {o_rsp_id, o_rsp_data}, e);
          end
        end
        check("onehot", ($countones(o_req_ready) <= 1), 1);
        prev_stall = o_rsp_valid && !i_rsp_ready;
        prev_data  = o_rsp_data;
        prev_id    = o_rsp_id;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [11:0] rr_sh;
  logic [3:0]  sv;
  logic [7:0]  sd[4];
  logic [2:0]  ss[4];

  initial begin
    i_rst       = 1'b1;
    i_req_valid = 4'b1111;
    i_req_data  = '0;
    i_req_shamt = '0;
    i_rsp_ready = 1'b1;
    #2;
    check("rst_valid", o_rsp_valid, 0);
    check("rst_data", o_rsp_data, 0);
    check("rst_id", o_rsp_id, 0);
    check("rst_ready", o_req_ready, 0);
    check("rst_busy", o_busy, 0);
    i_req_valid = 4'b0000;
    @(negedge clk);
    i_rst = 1'b0;

    // Round robin: data 01, shamt k on requester k.
    rr_sh = pack_s(3'd0, 3'd1, 3'd2, 3'd3);
    step(4'b1111, 32'h01010101, rr_sh, 1, 1, 4'b0001, {2'd0, 8'h01});
    step(4'b1111, 32'h01010101, rr_sh, 1, 1, 4'b0010, {2'd1, 8'h02});
    step(4'b1111, 32'h01010101, rr_sh, 1, 1, 4'b0100, {2'd2, 8'h04});
    step(4'b1111, 32'h01010101, rr_sh, 1, 1, 4'b1000, {2'd3, 8'h08});
    step(4'b1111, 32'h01010101, rr_sh, 1, 1, 4'b0001, {2'd0, 8'h01});

    // Single request on req0: B4 rotl 3 = A5.
    step(4'b0001, pack_d(8'hB4, 0, 0, 0), pack_s(3'd3, 0, 0, 0), 1, 1, 4'b0001, {2'd0, 8'hA5});

    // Backpressure with req1 waiting: 3C rotl 2 = F0.
    repeat (5)
      step(4'b0010, pack_d(0, 8'h3C, 0, 0), pack_s(0, 3'd2, 0, 0), 0, 1, 4'b0000, '0);
    step(4'b0010, pack_d(0, 8'h3C, 0, 0), pack_s(0, 3'd2, 0, 0), 1, 1, 4'b0010, {2'd1, 8'hF0});
    idle(1);

    // Move pointer to 3, then wrap past it and skip the idle requesters.
    step(4'b0100, pack_d(0, 0, 8'h81, 0), pack_s(0, 0, 3'd1, 0), 1, 1, 4'b0100, {2'd2, 8'h03});
    step(4'b0110, pack_d(0, 8'h0F, 8'h80, 0), pack_s(0, 3'd4, 3'd7, 0), 1, 1, 4'b0010, {2'd1, 8'hF0});
    step(4'b0100, pack_d(0, 8'h0F, 8'h80, 0), pack_s(0, 3'd4, 3'd7, 0), 1, 1, 4'b0100, {2'd2, 8'h40});
    idle(1);

    // Pending response on req1 (pointer -> 2), then reset mid-operation.
    step(4'b0010, pack_d(0, 8'h77, 0, 0), pack_s(0, 0, 0, 0), 0, 1, 4'b0010, {2'd1, 8'h77});
    idle(0);
    @(negedge clk);
    i_req_valid = 4'b0000;
    #1 i_rst = 1'b1;
    #1;
    check("midrst_valid", o_rsp_valid, 0);
    check("midrst_id", o_rsp_id, 0);
    check("midrst_data", o_rsp_data, 0);
    check("midrst_ready", o_req_ready, 0);
    exp_q.delete();
    m_ptr  = 0;
    m_full = 0;
    @(negedge clk);
    i_rst = 1'b0;
    // Pointer restarts at 0, so req1 wins over req3: 12 rotl 4 = 21.
    step(4'b1010, pack_d(0, 8'h12, 0, 8'h34), pack_s(0, 3'd4, 0, 3'd4), 1, 1, 4'b0010, {2'd1, 8'h21});
    idle(1);

    // Random soak against the model; requests stay up until granted.
    sv = '0;
    for (int i = 0; i < 4; i++) begin
      sd[i] = '0;
      ss[i] = '0;
    end
    last_grant = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!sv[i] || last_grant[i]) begin
          sv[i] = 1'($urandom_range(0, 1));
          sd[i] = 8'($urandom_range(0, 255));
          ss[i] = 3'($urandom_range(0, 7));
        end
      end
      step(sv, pack_d(sd[0], sd[1], sd[2], sd[3]), pack_s(ss[0], ss[1], ss[2], ss[3]),
           ($urandom_range(0, 3) != 0), 0, 4'b0000, '0);
    end
    repeat (3) idle(1);
    @(negedge clk);
    #5;
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
